// File: rtl/jogo_pkg.sv
// Shared types for the guessing-game round controller: FSM states, the
// one-hot guess classification and the first-attempt bonus value.
package jogo_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        ESPERA,
        AVALIA,
        FIM_RODADA,
        FIM_JOGO
    } estado_t;

    // Bit order matches the {acertou, perto, errou} output flags.
    typedef enum logic [2:0] {
        NENHUM  = 3'b000,
        ACERTOU = 3'b100,
        PERTO   = 3'b010,
        ERROU   = 3'b001
    } resultado_t;

    localparam int PONTOS_BONUS = 2;

    // Priority igual > ate3 > errada; nothing asserted also counts as wrong.
    function automatic resultado_t classifica(input logic igual,
                                              input logic ate3,
                                              input logic errada);
        if (igual)       return ACERTOU;
        else if (ate3)   return PERTO;
        else if (errada) return ERROU;
        else             return ERROU;
    endfunction

endpackage

// File: rtl/controle_rodada_detector_borda.sv
// Rising-edge detector for the debounced confirm button: one-cycle pulse on
// the first cycle the input is seen high.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic pulso
);

    logic anterior;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is synchronous, checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) anterior <= 1'b0;
        else        anterior <= entrada;
    end

    assign pulso = entrada & ~anterior;

endmodule

// File: rtl/controle_rodada.sv
// Round controller: counts attempts and rounds, latches the comparator
// classification and keeps a saturating score. Define CONTROLE_RODADA_BONUS_EN
// to award PONTOS_BONUS extra points for an exact guess on the first attempt.
module controle_rodada
    import jogo_pkg::*;
#(
    parameter int MAX_TENT    = 5,
    parameter int NUM_RODADAS = 3,
    parameter int W_PONTOS    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             iniciar,
    input  logic                             confirmar,
    input  logic                             igual,
    input  logic                             ate3,
    input  logic                             errada,
    output logic                             novo_segredo,
    output logic                             acertou,
    output logic                             perto,
    output logic                             errou,
    output logic [$clog2(MAX_TENT+1)-1:0]    tentativas,
    output logic [$clog2(NUM_RODADAS+1)-1:0] rodada,
    output logic [W_PONTOS-1:0]              pontos,
    output logic                             fim_jogo
);

    localparam int W_TENT = $clog2(MAX_TENT + 1);
    localparam int W_ROD  = $clog2(NUM_RODADAS + 1);
    localparam int W_SOMA = W_PONTOS + 1;

    estado_t           estado, proximo;
    resultado_t        resultado;
    logic              pulso;
    logic [W_ROD-1:0]  rodada_inc;
    logic [W_SOMA-1:0] incremento;
    logic [W_SOMA-1:0] soma;
    logic [W_PONTOS-1:0] pontos_sat;

    detector_borda u_borda (
        .clk     (clk),
        .rst_n   (rst_n),
        .entrada (confirmar),
        .pulso   (pulso)
    );

    assign rodada_inc = rodada + W_ROD'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= proximo;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO, FIM_JOGO: if (iniciar) proximo = CARREGA;
            CARREGA:          proximo = ESPERA;
            ESPERA:           if (pulso) proximo = AVALIA;
            AVALIA: begin
                if (resultado == ACERTOU || tentativas == W_TENT'(MAX_TENT))
                    proximo = FIM_RODADA;
                else
                    proximo = ESPERA;
            end
            FIM_RODADA:
                proximo = (rodada_inc == W_ROD'(NUM_RODADAS)) ? FIM_JOGO : CARREGA;
            default:          proximo = OCIOSO;
        endcase
    end

    // Score is summed one bit wider so the carry out selects saturation.
    always_comb begin
        incremento = W_SOMA'(MAX_TENT + 1) - W_SOMA'(tentativas);
`ifdef CONTROLE_RODADA_BONUS_EN
        if (tentativas == W_TENT'(1))
            incremento = incremento + W_SOMA'(PONTOS_BONUS);
`endif
        soma       = {1'b0, pontos} + incremento;
        pontos_sat = soma[W_SOMA-1] ? '1 : soma[W_PONTOS-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tentativas <= '0;
            rodada     <= '0;
            pontos     <= '0;
            resultado  <= NENHUM;
        end else begin
            case (estado)
                OCIOSO, FIM_JOGO: begin
                    if (iniciar) begin
                        tentativas <= '0;
                        rodada     <= '0;
                        pontos     <= '0;
                        resultado  <= NENHUM;
                    end
                end
                CARREGA: begin
                    tentativas <= '0;
                    resultado  <= NENHUM;
                end
                ESPERA: begin
                    if (pulso) begin
                        tentativas <= tentativas + W_TENT'(1);
                        resultado  <= classifica(igual, ate3, errada);
                    end
                end
                AVALIA:     if (resultado == ACERTOU) pontos <= pontos_sat;
                FIM_RODADA: rodada <= rodada_inc;
                default: ;
            endcase
        end
    end

    assign {acertou, perto, errou} = resultado;
    assign novo_segredo = (estado == CARREGA);
    assign fim_jogo     = (estado == FIM_JOGO);

endmodule

// File: tb/tb_controle_rodada.sv
// Scoreboard bench for controle_rodada: a cycle-free game model queues the
// expected outputs with the cycle they become valid; each clock drains the queue.
module tb_controle_rodada;

    localparam int MAX_TENT    = 5;
    localparam int NUM_RODADAS = 3;
    localparam int W_PONTOS    = 8;
`ifdef CONTROLE_RODADA_BONUS_EN
    localparam int BONUS = 2;
`else
    localparam int BONUS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n, iniciar, confirmar, igual, ate3, errada;
    logic novo_segredo, acertou, perto, errou, fim_jogo;
    logic [$clog2(MAX_TENT+1)-1:0]    tentativas;
    logic [$clog2(NUM_RODADAS+1)-1:0] rodada;
    logic [W_PONTOS-1:0]              pontos;

    controle_rodada #(
        .MAX_TENT    (MAX_TENT),
        .NUM_RODADAS (NUM_RODADAS),
        .W_PONTOS    (W_PONTOS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iniciar      (iniciar),
        .confirmar    (confirmar),
        .igual        (igual),
        .ate3         (ate3),
        .errada       (errada),
        .novo_segredo (novo_segredo),
        .acertou      (acertou),
        .perto        (perto),
        .errou        (errou),
        .tentativas   (tentativas),
        .rodada       (rodada),
        .pontos       (pontos),
        .fim_jogo     (fim_jogo)
    );

    always #5 clk = ~clk;

    typedef enum int {S_TENT, S_FLAGS, S_PONTOS, S_RODADA, S_NOVO, S_FIM} saida_t;
    typedef struct {
        int     ciclo;
        saida_t sel;
        string  tag;
        int     esp;
    } esperado_t;

    esperado_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int ciclo    = 0;
    int n_novo   = 0;
    int novo_esp = 0;
    int tent_m, rodada_m, pontos_m;

    always @(negedge clk) if (novo_segredo === 1'b1) n_novo++;

    task automatic verifica(input string tag, input int obs, input int esp);
        n_checks++;
        if (obs === esp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, esp, ciclo);
    endtask

    function automatic int le_saida(input saida_t s);
        case (s)
            S_TENT:   return int'(tentativas);
            S_FLAGS:  return int'({acertou, perto, errou});
            S_PONTOS: return int'(pontos);
            S_RODADA: return int'(rodada);
            S_NOVO:   return int'(novo_segredo);
            default:  return int'(fim_jogo);
        endcase
    endfunction

    function automatic int satura(input int v);
        return (v > (2**W_PONTOS) - 1) ? (2**W_PONTOS) - 1 : v;
    endfunction

    task automatic agenda(input int c, input saida_t s, input string tag, input int v);
        esperado_t e;
        e.ciclo = c; e.sel = s; e.tag = tag; e.esp = v;
        sb.push_back(e);
    endtask

    task automatic passo();
        esperado_t e;
        @(posedge clk);
        #1;
        ciclo++;
        while (sb.size() > 0 && sb[0].ciclo <= ciclo) begin
            e = sb.pop_front();
            verifica(e.tag, le_saida(e.sel), e.esp);
        end
    endtask

    task automatic verifica_zero(input string pre);
        for (int s = 0; s <= 5; s++)
            verifica($sformatf("%s_saida%0d", pre, s), le_saida(saida_t'(s)), 0);
    endtask

    task automatic inicia();
        iniciar  = 1'b1;
        pontos_m = 0;
        rodada_m = 0;
        tent_m   = 0;
        novo_esp++;
        agenda(ciclo + 1, S_NOVO,   "novo_apos_iniciar", 1);
        agenda(ciclo + 1, S_PONTOS, "pontos_iniciar",    0);
        agenda(ciclo + 1, S_TENT,   "tent_iniciar",      0);
        agenda(ciclo + 1, S_RODADA, "rodada_iniciar",    0);
        agenda(ciclo + 1, S_FLAGS,  "flags_iniciar",     0);
        agenda(ciclo + 1, S_FIM,    "fim_iniciar",       0);
        agenda(ciclo + 2, S_NOVO,   "novo_um_ciclo",     0);
        passo();
        iniciar = 1'b0;
        passo();
    endtask

    task automatic confirma(input logic i, input logic a, input logic e, input int segurar);
        int c0 = ciclo;
        int flag;
        int total;
        bit acabou = 1'b0;
        bit fim    = 1'b0;
        igual = i; ate3 = a; errada = e; confirmar = 1'b1;
        tent_m++;
        flag = i ? 4 : (a ? 2 : 1);
        agenda(c0 + 1, S_TENT,  "tentativas", tent_m);
        agenda(c0 + 1, S_FLAGS, "flags",      flag);
        if (i) begin
            pontos_m = satura(pontos_m + MAX_TENT - tent_m + 1 + ((tent_m == 1) ? BONUS : 0));
            acabou = 1'b1;
        end else if (tent_m == MAX_TENT) begin
            acabou = 1'b1;
        end
        agenda(c0 + 2, S_PONTOS, "pontos",        pontos_m);
        agenda(c0 + 2, S_FLAGS,  "flags_mantida", flag);
        if (acabou) begin
            rodada_m++;
            agenda(c0 + 3, S_RODADA, "rodada", rodada_m);
            if (rodada_m == NUM_RODADAS) begin
                fim = 1'b1;
                agenda(c0 + 3, S_FIM, "fim_jogo", 1);
            end else begin
                novo_esp++;
                agenda(c0 + 3, S_NOVO,  "novo_segredo",  1);
                agenda(c0 + 4, S_TENT,  "tent_limpa",    0);
                agenda(c0 + 4, S_FLAGS, "flags_limpas",  0);
                tent_m = 0;
            end
        end
        total = acabou ? (fim ? 3 : 4) : 2;
        for (int k = 1; k <= ((total > segurar) ? total : segurar); k++) begin
            passo();
            if (k == segurar) confirmar = 1'b0;
        end
        igual = 1'b0; ate3 = 1'b0; errada = 1'b0;
        passo();
    endtask

    initial begin
        rst_n = 1'b0; iniciar = 1'b0; confirmar = 1'b0;
        igual = 1'b0; ate3 = 1'b0; errada = 1'b0;
        passo();
        passo();
        verifica_zero("reset");
        rst_n = 1'b1;
        passo();

        // Game 1: exact first try, five misses, held button, exact second try.
        inicia();
        confirma(1'b1, 1'b0, 1'b0, 1);
        confirma(1'b0, 1'b0, 1'b1, 1);
        confirma(1'b0, 1'b1, 1'b0, 1);
        confirma(1'b0, 1'b0, 1'b1, 1);
        confirma(1'b0, 1'b0, 1'b0, 1);
        confirma(1'b0, 1'b0, 1'b1, 1);
        confirma(1'b0, 1'b0, 1'b1, 10);
        agenda(ciclo + 1, S_TENT, "segurado_uma_tentativa", 1);
        passo();
        confirma(1'b1, 1'b0, 1'b0, 1);

        // Confirm edge in FIM_JOGO is dropped.
        confirmar = 1'b1;
        passo();
        confirmar = 1'b0;
        passo();
        agenda(ciclo + 1, S_TENT, "borda_fora_espera", tent_m);
        agenda(ciclo + 1, S_FIM,  "fim_mantido",       1);
        passo();

        // Game 2: three rounds exact on the second attempt.
        inicia();
        iniciar = 1'b1;
        agenda(ciclo + 1, S_NOVO,   "iniciar_ignorado", 0);
        agenda(ciclo + 1, S_RODADA, "rodada_iniciar_ignorado", 0);
        passo();
        iniciar = 1'b0;
        passo();
        for (int r = 0; r < NUM_RODADAS; r++) begin
            confirma(1'b0, 1'b0, 1'b1, 1);
            confirma(1'b1, 1'b0, 1'b0, 1);
        end
        verifica("pontos_jogo2_modelo", int'(pontos), 12);

        // Game 3: reset while in AVALIA after scoring a round.
        inicia();
        confirma(1'b1, 1'b0, 1'b0, 1);
        errada = 1'b1; confirmar = 1'b1;
        passo();
        verifica("tent_antes_reset", int'(tentativas), 1);
        verifica("pontos_antes_reset", int'(pontos), 5 + BONUS);
        confirmar = 1'b0; errada = 1'b0; rst_n = 1'b0;
        passo();
        verifica_zero("reset_avalia");
        rst_n = 1'b1;
        passo();
        verifica_zero("apos_reset");

        verifica("pulsos_novo_segredo", n_novo, novo_esp);
        verifica("scoreboard_vazio", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
